mem_line_sequencer: RTL and testbench
=====================================

Name: mem_line_sequencer

Overview:
- Request-side sequencer sitting directly upstream of a bank of 2**ADDR_WIDTH memory-line cells.
- Accepts single read/write requests over a valid/ready handshake.
- Decodes the address into a one-hot line select and drives the write strobe, read strobe and write data for the cells.
- Samples the shared tri-state read bus and returns read data as a one-cycle response pulse.

Parameters:
- ADDR_WIDTH, 3, line address width; number of lines NUM_LINES = 2**ADDR_WIDTH
- DATA_WIDTH, 8, width of one memory line

Ports:
- clock  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request this cycle
- req_write  input  1  1 = write, 0 = read; sampled on accept
- req_addr  input  ADDR_WIDTH  target line index; sampled on accept
- req_wdata  input  DATA_WIDTH  write data; sampled on accept
- rsp_valid  output  1  one-cycle pulse, read data valid
- rsp_rdata  output  DATA_WIDTH  read data; holds its value until the next read response
- line_select  output  NUM_LINES  one-hot line select to cells
- write_en  output  1  write strobe to cells
- read_en  output  1  read strobe to cells, enabling the selected cell's bus driver
- wr_data  output  DATA_WIDTH  data to cells' data inputs
- bus_rdata  input  DATA_WIDTH  shared tri-state read bus from cells
- verify_err  output  1  sticky write-verify mismatch flag; see Optional Feature

Behaviour:
- Reset (reset=1 at a posedge):
  - State goes to IDLE.
  - line_select, write_en, read_en, wr_data, rsp_valid, rsp_rdata and verify_err all go to 0.
  - req_ready is 1 from the first cycle after reset.
- All cell-facing outputs are registered; none are combinational from inputs.
- States: IDLE, WRITE, READ (plus VERIFY when the optional feature is compiled in).
- IDLE:
  - req_ready=1.
  - line_select=0, write_en=0, read_en=0, so the read bus floats.
  - On posedge with req_valid=1: latch addr, wdata and write; go to WRITE if write=1, else READ.
- WRITE (one cycle):
  - line_select = 1<<addr, write_en=1, wr_data=latched wdata, req_ready=0.
  - The cell captures the data at the posedge ending this cycle.
  - Next state is IDLE.
  - Writes produce no rsp_valid.
- READ (one cycle):
  - line_select = 1<<addr, read_en=1, req_ready=0.
  - At the posedge ending this cycle: rsp_rdata <= bus_rdata, rsp_valid <= 1 for exactly one cycle, next state IDLE.
- Latency, with the request accepted at edge k:
  - Strobes are high during cycle k+1.
  - Read: rsp_valid and data are present in cycle k+2.
  - req_ready returns to 1 in cycle k+2.
  - Maximum throughput is one request per 2 cycles.
- There is no response backpressure; rsp_valid is a pulse.
- A new request may be accepted in the same cycle that rsp_valid is high.
- Invariants:
  - write_en and read_en are never high together.
  - line_select is one-hot when either strobe is high and all-zero otherwise.
  - A strobe is never high for more than one consecutive cycle per transaction.
- Every address value is legal, since NUM_LINES = 2**ADDR_WIDTH.
- Reset mid-transaction:
  - The transaction is dropped and no rsp_valid is issued.
  - Strobes go low at that edge.
- req_valid deasserted while req_ready=0 has no effect; no request is latched outside IDLE.

Optional Feature:
- Macro: WRITE_VERIFY_EN.
- Defined:
  - WRITE goes to VERIFY instead of IDLE.
  - VERIFY (one cycle): same line_select, read_en=1, write_en=0, req_ready=0.
  - At the edge ending VERIFY, bus_rdata is compared to the latched wdata; on mismatch verify_err <= 1.
  - verify_err is sticky and cleared only by reset.
  - No rsp_valid is issued for VERIFY.
  - Write occupancy becomes 2 cycles; req_ready returns in cycle k+3.
- Not defined:
  - The VERIFY state is absent and verify_err is tied to 0.
  - Write timing is as in Behaviour.

Test Plan:
- Reset check: hold reset 2 cycles with req_valid=1 -> all outputs 0; req_ready=1 in the first cycle after release; no strobe pulses.
- Write: accept write, addr=5, wdata=0xA5 -> next cycle line_select=0x20, write_en=1, wr_data=0xA5, read_en=0; then IDLE, req_ready=1, no rsp_valid.
- Read: bench cell model drives bus_rdata=0x3C when line_select[2]&read_en; accept read addr=2 -> read_en high for 1 cycle; rsp_valid=1 and rsp_rdata=0x3C exactly 2 cycles after accept.
- Back-to-back: req_valid held high with alternating write addr 7 data 0xFF and read addr 7 -> accepts every 2nd cycle; read returns 0xFF; strobes never overlap.
- Reset mid-read: assert reset in the READ cycle -> no rsp_valid, read_en and line_select 0 after that edge, rsp_rdata=0.
- WRITE_VERIFY_EN defined: write addr 1 data 0x55; model returns 0x55 -> verify_err stays 0, req_ready returns at k+3; repeat with model returning 0x54 -> verify_err=1 and remains 1 through later good writes until reset.

Source files
------------

// File: rtl/mem_line_sequencer.sv
// Request sequencer for a bank of memory-line cells: one-hot line decode, strobes, read response.
// Define WRITE_VERIFY_EN to add a read-back check after every write (sticky verify_err).
module mem_line_sequencer #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LINES  = 2**ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [NUM_LINES-1:0]  line_select,
  output logic                  write_en,
  output logic                  read_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  verify_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    READ   = 2'd2
`ifdef WRITE_VERIFY_EN
    ,VERIFY = 2'd3
`endif
  } state_t;

  state_t state_reg;
  logic [NUM_LINES-1:0] addr_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_decode
      assign addr_onehot[gi] = (req_addr == ADDR_WIDTH'(gi));
    end
  endgenerate

  // Ready depends only on state, never on request inputs.
  assign req_ready = (state_reg == IDLE);

`ifndef WRITE_VERIFY_EN
  assign verify_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      line_select <= '0;
      write_en    <= 1'b0;
      read_en     <= 1'b0;
      wr_data     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
`ifdef WRITE_VERIFY_EN
      verify_err  <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            line_select <= addr_onehot;
            if (req_write) begin
              state_reg <= WRITE;
              write_en  <= 1'b1;
              wr_data   <= req_wdata;
            end else begin
              state_reg <= READ;
              read_en   <= 1'b1;
            end
          end
        end
        WRITE: begin
          write_en <= 1'b0;
`ifdef WRITE_VERIFY_EN
          // Keep the line selected and turn its bus driver on for the read-back.
          read_en   <= 1'b1;
          state_reg <= VERIFY;
`else
          line_select <= '0;
          state_reg   <= IDLE;
`endif
        end
        READ: begin
          read_en     <= 1'b0;
          line_select <= '0;
          rsp_rdata   <= bus_rdata;
          rsp_valid   <= 1'b1;
          state_reg   <= IDLE;
        end
`ifdef WRITE_VERIFY_EN
        VERIFY: begin
          read_en     <= 1'b0;
          line_select <= '0;
          if (bus_rdata != wr_data) verify_err <= 1'b1;
          state_reg   <= IDLE;
        end
`endif
        default: begin
          state_reg   <= IDLE;
          read_en     <= 1'b0;
          write_en    <= 1'b0;
          line_select <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_sequencer.sv
// Directed bench for mem_line_sequencer with a behavioural cell bank on the read bus.
// Compile with WRITE_VERIFY_EN defined to exercise the read-back check.
module tb_mem_line_sequencer;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int NL = 2**AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [NL-1:0] line_select;
  logic          write_en;
  logic          read_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] bus_rdata;
  logic          verify_err;

  int assertions = 0;
  int failures   = 0;

  logic [DW-1:0] mem [NL];
  logic          corrupt = 1'b0;
  logic          mon_en = 1'b0;
  logic          prev_we = 1'b0;
  logic          prev_re = 1'b0;

  always #5 clock = ~clock;

  mem_line_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .line_select(line_select), .write_en(write_en), .read_en(read_en),
    .wr_data(wr_data), .bus_rdata(bus_rdata), .verify_err(verify_err)
  );

  // Cell bank: selected cell drives the bus while read_en is high; corrupt flips bit 0.
  always_comb begin
    bus_rdata = '0;
    if (read_en)
      for (int i = 0; i < NL; i++)
        if (line_select[i]) bus_rdata = mem[i] ^ {{(DW-1){1'b0}}, corrupt};
  end

  always @(posedge clock)
    if (write_en)
      for (int i = 0; i < NL; i++)
        if (line_select[i]) mem[i] <= wr_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobe invariants, sampled mid-cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      logic onehot_ok;
      onehot_ok = (write_en || read_en) ? ($countones(line_select) == 1) : (line_select == '0);
      check("inv_no_overlap", {31'b0, write_en & read_en}, 32'd0);
      check("inv_onehot", {31'b0, onehot_ok}, 32'd1);
      check("inv_single_pulse", {30'b0, write_en & prev_we, read_en & prev_re}, 32'd0);
      prev_we <= write_en;
      prev_re <= read_en;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic request(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < NL; i++) mem[i] = '0;
    mem[2] = 8'h3C;

    // Reset held two cycles with a request pending.
    request(1'b1, 3'd5, 8'hA5);
    tick();
    mon_en = 1'b1;
    tick();
    check("rst_line_select", {24'b0, line_select}, 32'h0);
    check("rst_write_en", {31'b0, write_en}, 32'h0);
    check("rst_read_en", {31'b0, read_en}, 32'h0);
    check("rst_wr_data", {24'b0, wr_data}, 32'h0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", {24'b0, rsp_rdata}, 32'h0);
    check("rst_verify_err", {31'b0, verify_err}, 32'h0);
    reset = 1'b0;
    req_valid = 1'b0;
    tick();
    check("rst_ready_after", {31'b0, req_ready}, 32'h1);
    check("rst_no_strobe", {30'b0, write_en, read_en}, 32'h0);
    $display("txn reset: ready=%0b", req_ready);

    // Write addr 5, 0xA5.
    request(1'b1, 3'd5, 8'hA5);
    tick();
    req_valid = 1'b0;
    check("wr_line_select", {24'b0, line_select}, 32'h20);
    check("wr_write_en", {31'b0, write_en}, 32'h1);
    check("wr_wr_data", {24'b0, wr_data}, 32'hA5);
    check("wr_read_en", {31'b0, read_en}, 32'h0);
    check("wr_ready_busy", {31'b0, req_ready}, 32'h0);
    tick();
`ifdef WRITE_VERIFY_EN
    check("wr_verify_phase", {31'b0, read_en}, 32'h1);
    tick();
`endif
    check("wr_ready_back", {31'b0, req_ready}, 32'h1);
    check("wr_no_rsp", {31'b0, rsp_valid}, 32'h0);
    check("wr_mem5", {24'b0, mem[5]}, 32'hA5);
    $display("txn write addr=5 data=a5");

    // Read addr 2 (model holds 0x3C).
    request(1'b0, 3'd2, 8'h00);
    tick();
    req_valid = 1'b0;
    check("rd_read_en", {31'b0, read_en}, 32'h1);
    check("rd_line_select", {24'b0, line_select}, 32'h04);
    check("rd_rsp_early", {31'b0, rsp_valid}, 32'h0);
    tick();
    check("rd_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    check("rd_rsp_rdata", {24'b0, rsp_rdata}, 32'h3C);
    check("rd_read_en_off", {31'b0, read_en}, 32'h0);
    check("rd_ready_back", {31'b0, req_ready}, 32'h1);
    tick();
    check("rd_rsp_pulse", {31'b0, rsp_valid}, 32'h0);
    check("rd_rdata_hold", {24'b0, rsp_rdata}, 32'h3C);
    $display("txn read addr=2 data=%0h", rsp_rdata);

    // Back-to-back with req_valid held high: write 7/0xFF, read 7, twice.
    for (int t = 0; t < 4; t++) begin
      logic wr;
      wr = (t % 2 == 0);
      request(wr, 3'd7, 8'hFF);
      tick();
      check("b2b_busy", {31'b0, req_ready}, 32'h0);
      check("b2b_strobe", {30'b0, write_en, read_en}, wr ? 32'h2 : 32'h1);
      tick();
`ifdef WRITE_VERIFY_EN
      if (wr) tick();
`endif
      check("b2b_ready", {31'b0, req_ready}, 32'h1);
      check("b2b_rsp_valid", {31'b0, rsp_valid}, wr ? 32'h0 : 32'h1);
      if (!wr) check("b2b_rdata", {24'b0, rsp_rdata}, 32'hFF);
      $display("txn b2b %s addr=7 rsp_valid=%0b rdata=%0h", wr ? "write" : "read", rsp_valid, rsp_rdata);
    end
    req_valid = 1'b0;
    tick();

    // Reset during the READ cycle drops the transaction.
    request(1'b0, 3'd2, 8'h00);
    tick();
    req_valid = 1'b0;
    check("mid_in_read", {31'b0, read_en}, 32'h1);
    reset = 1'b1;
    tick();
    check("mid_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("mid_read_en", {31'b0, read_en}, 32'h0);
    check("mid_line_select", {24'b0, line_select}, 32'h0);
    check("mid_rsp_rdata", {24'b0, rsp_rdata}, 32'h0);
    reset = 1'b0;
    tick();
    check("mid_no_late_rsp", {31'b0, rsp_valid}, 32'h0);
    check("mid_ready", {31'b0, req_ready}, 32'h1);
    $display("txn reset-mid-read rsp_valid=%0b", rsp_valid);

`ifdef WRITE_VERIFY_EN
    // Good read-back.
    request(1'b1, 3'd1, 8'h55);
    tick();
    req_valid = 1'b0;
    tick();
    check("ver_read_en", {31'b0, read_en}, 32'h1);
    check("ver_write_en", {31'b0, write_en}, 32'h0);
    check("ver_line_select", {24'b0, line_select}, 32'h02);
    check("ver_busy", {31'b0, req_ready}, 32'h0);
    tick();
    check("ver_ready_k3", {31'b0, req_ready}, 32'h1);
    check("ver_err_good", {31'b0, verify_err}, 32'h0);
    check("ver_no_rsp", {31'b0, rsp_valid}, 32'h0);
    $display("txn verify-good addr=1 err=%0b", verify_err);

    // Bad read-back sets the sticky flag.
    corrupt = 1'b1;
    request(1'b1, 3'd1, 8'h55);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    corrupt = 1'b0;
    check("ver_err_bad", {31'b0, verify_err}, 32'h1);
    $display("txn verify-bad addr=1 err=%0b", verify_err);

    request(1'b1, 3'd3, 8'h11);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("ver_err_sticky", {31'b0, verify_err}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ver_err_cleared", {31'b0, verify_err}, 32'h0);
    $display("txn verify-sticky-then-reset err=%0b", verify_err);
`else
    check("noverify_err_tied", {31'b0, verify_err}, 32'h0);
`endif

    tick();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
